cart_bus_mux: RTL

Parametrised cartridge-side bus multiplexer between the SNES core and N_CH coprocessor mapper channels; channel 0 is the default mapper (DSP/LoROM/HiROM), channels 1..N_CH-1 are special-chip mappers with one `map_active` bit each. Unlike a purely combinational select, it switches channels through a drain/guard-gap state machine. Strobes never glitch between mappers, and invalid multi-hot requests are detected. It drives the core's `di`/`irq_n`, the ROM port and the BSRAM port.

---
 rtl/cart_mux_pkg.sv | 8 +
 rtl/cart_mux_sel_enc.sv | 26 ++
 rtl/cart_bus_mux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cart_mux_pkg.sv
// cart_mux_pkg: shared state encoding, open-bus value and request-vector helper for cart_bus_mux.
package cart_mux_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, GAP} state_t;
    localparam logic [7:0] OPEN_BUS = 8'hFF;
    function automatic logic onehot_or_zero(input logic [15:0] vec);
        return (vec & (vec - 16'd1)) == 16'd0;
    endfunction
endpackage

// File: rtl/cart_mux_sel_enc.sv
// cart_mux_sel_enc: map_active -> requested channel; CART_MUX_MULTIHOT_CHK_EN rejects multi-hot requests
// (req_sel forced to 0, multihot raised), otherwise the lowest set bit wins.
module cart_mux_sel_enc
    import cart_mux_pkg::*;
#(
    parameter int N_CH = 6,
    localparam int SW = $clog2(N_CH)
) (
    input  logic [N_CH-2:0] map_active,
    output logic [SW-1:0]   req_sel,
    output logic            multihot
);
    always_comb begin
        req_sel = '0;
        for (int i = N_CH - 2; i >= 0; i--)
            if (map_active[i]) req_sel = SW'(i + 1);
`ifdef CART_MUX_MULTIHOT_CHK_EN
        if (!onehot_or_zero(16'(map_active))) req_sel = '0;
`endif
    end
`ifdef CART_MUX_MULTIHOT_CHK_EN
    assign multihot = !onehot_or_zero(16'(map_active));
`else
    assign multihot = 1'b0;
`endif
endmodule

// File: rtl/cart_bus_mux.sv
// cart_bus_mux: glitch-free cartridge bus mux with drain/guard-gap channel switching.
// Multi-hot request checking is enabled by CART_MUX_MULTIHOT_CHK_EN (see cart_mux_sel_enc).
module cart_bus_mux
    import cart_mux_pkg::*;
#(
    parameter int N_CH = 6,
    parameter int ROM_AW = 24,
    parameter int BSRAM_AW = 20,
    parameter int GAP_CYCLES = 2,
    parameter int DRAIN_MAX = 255,
    parameter logic [N_CH-1:0] TURBO_BLOCK_MASK = 'b01010,
    localparam int SW = $clog2(N_CH)
) (
    input  logic                     mclk,
    input  logic                     reset,
    input  logic [N_CH-2:0]          map_active,
    input  logic [N_CH*8-1:0]        ch_do,
    input  logic [N_CH-1:0]          ch_irq_n,
    input  logic [N_CH*ROM_AW-1:0]   ch_rom_addr,
    input  logic [N_CH-1:0]          ch_rom_ce_n,
    input  logic [N_CH-1:0]          ch_rom_oe_n,
    input  logic [N_CH-1:0]          ch_rom_word,
    input  logic [N_CH*BSRAM_AW-1:0] ch_bsram_addr,
    input  logic [N_CH*8-1:0]        ch_bsram_d,
    input  logic [N_CH-1:0]          ch_bsram_ce_n,
    input  logic [N_CH-1:0]          ch_bsram_oe_n,
    input  logic [N_CH-1:0]          ch_bsram_we_n,
    output logic [7:0]               di,
    output logic                     irq_n,
    output logic [ROM_AW-1:0]        rom_addr,
    output logic                     rom_ce_n,
    output logic                     rom_oe_n,
    output logic                     rom_word,
    output logic [BSRAM_AW-1:0]      bsram_addr,
    output logic [7:0]               bsram_d,
    output logic                     bsram_ce_n,
    output logic                     bsram_oe_n,
    output logic                     bsram_we_n,
    output logic [SW-1:0]            sel,
    output logic                     map_busy,
    output logic                     turbo_allow,
    output logic                     drain_timeout,
    output logic                     multihot_err
);
    localparam int CMAX = DRAIN_MAX > GAP_CYCLES ? DRAIN_MAX : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    state_t state, state_nx;
    logic [SW-1:0] cur_sel, sel_nx, req_sel;
    logic [CW-1:0] cnt, cnt_nx;
    logic to_nx, multihot, idle, gap;

    cart_mux_sel_enc #(.N_CH(N_CH)) u_enc (
        .map_active(map_active),
        .req_sel(req_sel),
        .multihot(multihot)
    );

    assign idle = ch_rom_ce_n[cur_sel] && ch_bsram_ce_n[cur_sel];

    always_ff @(posedge mclk) begin
        if (reset) begin
            state <= GAP;
            cnt <= '0;
            cur_sel <= '0;
            drain_timeout <= 1'b0;
            multihot_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            cur_sel <= sel_nx;
            drain_timeout <= to_nx;
            multihot_err <= multihot_err | multihot;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        sel_nx = cur_sel;
        to_nx = 1'b0;
        case (state)
            RUN: if (req_sel != cur_sel) begin
                state_nx = DRAIN;
                cnt_nx = '0;
            end
            DRAIN: if (req_sel == cur_sel) begin
                state_nx = RUN;
            end else if (idle || cnt == CW'(DRAIN_MAX - 1)) begin
                state_nx = GAP;
                cnt_nx = '0;
                to_nx = !idle;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
                state_nx = RUN;
                sel_nx = req_sel;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            default: state_nx = GAP;
        endcase
    end

    // GAP parks the bus: strobes inactive, open-bus read data, zeroed addresses.
    assign gap = state == GAP;
    assign di = gap ? OPEN_BUS : ch_do[cur_sel*8 +: 8];
    assign irq_n = gap ? 1'b1 : ch_irq_n[cur_sel];
    assign rom_addr = gap ? '0 : ch_rom_addr[cur_sel*ROM_AW +: ROM_AW];
    assign rom_ce_n = gap ? 1'b1 : ch_rom_ce_n[cur_sel];
    assign rom_oe_n = gap ? 1'b1 : ch_rom_oe_n[cur_sel];
    assign rom_word = gap ? 1'b0 : ch_rom_word[cur_sel];
    assign bsram_addr = gap ? '0 : ch_bsram_addr[cur_sel*BSRAM_AW +: BSRAM_AW];
    assign bsram_d = gap ? 8'h00 : ch_bsram_d[cur_sel*8 +: 8];
    assign bsram_ce_n = gap ? 1'b1 : ch_bsram_ce_n[cur_sel];
    assign bsram_oe_n = gap ? 1'b1 : ch_bsram_oe_n[cur_sel];
    assign bsram_we_n = gap ? 1'b1 : ch_bsram_we_n[cur_sel];
    assign sel = cur_sel;
    assign map_busy = state != RUN;
    assign turbo_allow = state == RUN && !TURBO_BLOCK_MASK[cur_sel];
endmodule
